// File: rtl/sync_trig_pkg.sv
// Shared constants, channel register record and phase clamp helper for sync_trigger_gen.
package sync_trig_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_HIGH   = 2'd1;
    localparam logic [1:0] ADDR_PHASE  = 2'd2;
    localparam logic [1:0] ADDR_EN     = 2'd3;

    // Sized at the widest supported counter; narrower builds zero-extend into it.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] high;
        logic [CNT_W_DEF-1:0] phase;
    } ch_regs_t;

    function automatic logic [CNT_W_DEF-1:0] clamp_phase(input ch_regs_t r);
        return (r.phase > r.period) ? '0 : r.phase;
    endfunction

endpackage

// File: rtl/sync_trig_ch.sv
// One trigger channel: shadow/active registers, period counter, registered trig and wrap.
module sync_trig_ch
    import sync_trig_pkg::*;
#(
    parameter int unsigned DEF_PERIOD = 49999999,
    parameter int unsigned DEF_HIGH   = 4999999
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [1:0]           addr,
    input  logic [CNT_W_DEF-1:0] data,
    input  logic                 pps_pulse,
    output logic                 trig,
    output logic                 wrap
);

    localparam ch_regs_t REGS_RST = '{
        period: CNT_W_DEF'(DEF_PERIOD),
        high:   CNT_W_DEF'(DEF_HIGH),
        phase:  '0
    };

    ch_regs_t             shd_q, shd_d;
    ch_regs_t             act_q, act_d;
    logic [CNT_W_DEF-1:0] cnt_q, cnt_d;
    logic                 en_q, en_d;
    logic                 trig_q, trig_d;
    logic                 wrap_q, wrap_d;
    logic                 resync;

    always_comb begin
        shd_d = shd_q;
        en_d  = en_q;
        if (we) begin
            unique case (addr)
                ADDR_PERIOD: shd_d.period = data;
                ADDR_HIGH:   shd_d.high   = data;
                ADDR_PHASE:  shd_d.phase  = data;
                ADDR_EN:     en_d         = data[0];
            endcase
        end

        // A PPS edge on a running channel overrides a concurrent enable write.
        resync = pps_pulse && en_q;
        if (resync) begin
            en_d = 1'b1;
        end

        act_d  = act_q;
        cnt_d  = cnt_q + CNT_W_DEF'(1);
        wrap_d = 1'b0;
        if (!en_d) begin
            act_d = shd_d;
            cnt_d = '0;
        end else if (resync || !en_q) begin
            act_d = shd_d;
            cnt_d = clamp_phase(shd_d);
        end else if (cnt_q == act_q.period) begin
            act_d  = shd_d;
            cnt_d  = '0;
            wrap_d = 1'b1;
        end

        // Held low on the enabling edge so the first pulse reflects the loaded phase.
        trig_d = en_q && en_d && (cnt_q < act_q.high);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            shd_q  <= REGS_RST;
            act_q  <= REGS_RST;
            cnt_q  <= '0;
            en_q   <= 1'b1;
            trig_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            shd_q  <= shd_d;
            act_q  <= act_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            trig_q <= trig_d;
            wrap_q <= wrap_d;
        end
    end

    assign trig = trig_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/sync_trigger_gen.sv
// Multi-channel trigger/PWM generator with config write decode and optional PPS re-alignment.
// Define SYNC_PPS_EN to build the pps_in synchroniser and resync path.
module sync_trigger_gen
    import sync_trig_pkg::*;
#(
    parameter int unsigned N_CH       = 5,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DEF_PERIOD = 49999999,
    parameter int unsigned DEF_HIGH   = 4999999
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             pps_in,
    output logic [N_CH-1:0]  trig,
    output logic [N_CH-1:0]  wrap
);

    logic                 cfg_valid;
    logic [CNT_W_DEF-1:0] wr_data;
    logic                 pps_pulse;

    assign cfg_valid = cfg_we && (32'(cfg_ch) < N_CH);
    assign wr_data   = CNT_W_DEF'(cfg_data);

`ifdef SYNC_PPS_EN
    // [0],[1] synchronise; [2] holds the previous synchronised level for edge detect.
    logic [2:0] pps_sync_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            pps_sync_q <= '0;
        end else begin
            pps_sync_q <= {pps_sync_q[1:0], pps_in};
        end
    end

    assign pps_pulse = pps_sync_q[1] & ~pps_sync_q[2];
`else
    logic unused_pps;
    assign unused_pps = pps_in;
    assign pps_pulse  = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sync_trig_ch #(
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk_50m   (clk_50m),
            .rst_n     (rst_n),
            .we        (cfg_valid && (cfg_ch == 4'(i))),
            .addr      (cfg_addr),
            .data      (wr_data),
            .pps_pulse (pps_pulse),
            .trig      (trig[i]),
            .wrap      (wrap[i])
        );
    end

endmodule

// File: doc/sync_trigger_gen.md
# sync_trigger_gen

Parametrised multi-channel trigger/PWM generator for sensor time synchronisation. Each channel produces a periodic pulse train with runtime-programmable period, high time, phase offset and enable. New settings take effect glitch-free at the channel's period boundary. All channels can be re-aligned to an external pulse-per-second (PPS) edge. It replaces fixed-constant trigger generation and sits between the host configuration bus and the camera/IMU/LiDAR trigger pins.

## Interface
- N_CH, 5, number of trigger channels (1..16)
- CNT_W, 32, counter/register width
- DEF_PERIOD, 49999999, reset value of every period register (terminal count, period = value+1 cycles)
- DEF_HIGH, 4999999, reset value of every high-time register (cycles high per period)
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_ch  in  4  target channel index
- cfg_addr  in  2  0=period, 1=high, 2=phase, 3=enable (bit 0)
- cfg_data  in  CNT_W  write data
- pps_in  in  1  external PPS, asynchronous to clk_50m
- trig  out  N_CH  registered trigger outputs
- wrap  out  N_CH  one-cycle pulse when a channel's counter returns to 0

## Operation
- Per channel: active regs (period, high, phase), shadow regs (same), enable bit, counter cnt.
- Reset: all shadow/active period=DEF_PERIOD, high=DEF_HIGH, phase=0, enable=1, cnt=0, trig=0, wrap=0, PPS synchroniser=0.
- Counting (enabled): cnt increments each cycle. At cnt==period it loads 0, asserts wrap next cycle, and copies shadow to active (commit).
- trig[i] <= en & (cnt < high). high=0 gives constant low. high > period gives constant high. period=0 gives cnt fixed at 0 and wrap every cycle.
- Writes to addr 0-2 update the shadow only. A write in the same cycle as a commit is committed (write bypasses shadow).
- Enable write: takes effect immediately.
  - 1->0: cnt forced to 0; trig and wrap low from next cycle; shadow committed every cycle while disabled.
  - 0->1: cnt loads phase, clamped to 0 if phase > period.
- cfg_ch >= N_CH: write ignored.
- PPS resync: a rising edge of synchronised pps_in forces every enabled channel to commit shadow and load cnt=phase (clamped as above), no wrap pulse.
  - PPS has priority over a simultaneous wrap or enable write.
  - A cfg write in the same cycle is included in the commit.
- Asynchronous reset mid-period: all state returns to reset values instantly; counting restarts at the first clock after release.

## Timing
- trig and wrap are registered: 1-cycle latency from cnt.
- After reset release at edge 0: cnt=1 at edge 1, trig=1 after edge 1 (DEF_HIGH>0).
- Config write at edge k lands in shadow at k. Commit occurs at the next wrap; the new period is visible from the following cycle.
- PPS: pps_in high before edge k → synchroniser stage 2 at k+1 → edge detect → cnt=phase at edge k+2 → trig reflects it at k+3.
- Minimum PPS pulse width: 2 clk_50m cycles. Shorter pulses may be missed.

## Configuration
- SYNC_PPS_EN defined: two-flop synchroniser, edge detector and resync logic present as above.
- Undefined: pps_in port remains but is unused. Channels align only on reset and enable.

## Structure
- Package sync_trig_pkg: CNT_W default, cfg_addr constants (ADDR_PERIOD, ADDR_HIGH, ADDR_PHASE, ADDR_EN), channel register record typedef.
- Sub-module sync_trig_ch: one channel (shadow/active regs, counter, trig/wrap), instantiated N_CH times by generate.
- The top holds the write decode and the PPS synchroniser.

## Test plan
- Simulation overrides: DEF_PERIOD=9, DEF_HIGH=3.
- Reset release → each trig is high 3 cycles, low 7 cycles, repeating. wrap pulses every 10 cycles, all channels aligned.
- Write period=4 to ch2 mid-period → ch2 completes the current 10-cycle period, then runs at a 5-cycle period. Other channels are unchanged.
- Write high=0 to ch1, then high=20 → ch1 constant low after the next wrap, then constant high after the following wrap.
- Write phase=5 to ch3, disable then enable ch3 → ch3's wrap is 5 cycles earlier than ch0's wrap.
- (SYNC_PPS_EN) Set ch4 phase=2, raise pps_in for 3 cycles mid-period → 2 cycles later all channels restart: ch4 cnt=2, others cnt=0, no spurious wrap.
- Assert rst_n low for 1 cycle mid-high → trig=0 immediately, registers restored to defaults, pattern restarts from cnt=0.
